// File: rtl/sram_arbiter.sv
// Two-port arbiter and strobe sequencer for an external asynchronous 16-bit SRAM.
// Port A (CPU) and port B (DMA/video) share the chip; round-robin on contention.
module sram_arbiter #(
   parameter int ADDR_WIDTH = 18,
   parameter int DATA_WIDTH = 16,
   parameter int READ_WAIT  = 1,
   parameter int WRITE_WAIT = 1
) (
   input  logic                  io_mainClk,
   input  logic                  io_resetn,
   input  logic                  io_a_req,
   input  logic                  io_a_we,
   input  logic [ADDR_WIDTH-1:0] io_a_addr,
   input  logic [DATA_WIDTH-1:0] io_a_wdata,
   input  logic [1:0]            io_a_be,
   output logic                  io_a_ack,
   input  logic                  io_b_req,
   input  logic                  io_b_we,
   input  logic [ADDR_WIDTH-1:0] io_b_addr,
   input  logic [DATA_WIDTH-1:0] io_b_wdata,
   input  logic [1:0]            io_b_be,
   output logic                  io_b_ack,
   output logic [DATA_WIDTH-1:0] io_rdata,
   output logic                  io_busy,
   output logic [ADDR_WIDTH-1:0] io_sram_addr,
   input  logic [DATA_WIDTH-1:0] io_sram_dat_read,
   output logic [DATA_WIDTH-1:0] io_sram_dat_write,
   output logic                  io_sram_dat_writeEnable,
   output logic                  io_sram_cs,
   output logic                  io_sram_oe,
   output logic                  io_sram_we,
   output logic                  io_sram_ub,
   output logic                  io_sram_lb
);

   typedef enum logic [2:0] {IDLE, RD, WR, WHOLD, DONE} state_t;

   localparam logic [3:0] RD_LAST = 4'(READ_WAIT);
   localparam logic [3:0] WR_LAST = 4'(WRITE_WAIT);

   state_t                  state_reg;
   logic [3:0]              cnt_reg;
   logic                    last_grant_reg;   // 1 = port B was granted last
   logic                    grant_b_reg;      // owner of the access in flight

   logic                    pick_b;
   logic                    sel_we;
   logic [ADDR_WIDTH-1:0]   sel_addr;
   logic [DATA_WIDTH-1:0]   sel_wdata;
   logic [1:0]              sel_be;

   // B wins when it is alone, or on a tie when A was served last.
   assign pick_b    = io_b_req && (!io_a_req || !last_grant_reg);
   assign sel_we    = pick_b ? io_b_we    : io_a_we;
   assign sel_addr  = pick_b ? io_b_addr  : io_a_addr;
   assign sel_wdata = pick_b ? io_b_wdata : io_a_wdata;
   assign sel_be    = pick_b ? io_b_be    : io_a_be;

   assign io_busy = (state_reg != IDLE);

   always_ff @(posedge io_mainClk) begin
      if (!io_resetn) begin
         state_reg               <= IDLE;
         cnt_reg                 <= 4'd0;
         last_grant_reg          <= 1'b1;
         grant_b_reg             <= 1'b0;
         io_a_ack                <= 1'b0;
         io_b_ack                <= 1'b0;
         io_rdata                <= '0;
         io_sram_addr            <= '0;
         io_sram_dat_write       <= '0;
         io_sram_dat_writeEnable <= 1'b0;
         io_sram_cs              <= 1'b1;
         io_sram_oe              <= 1'b1;
         io_sram_we              <= 1'b1;
         io_sram_ub              <= 1'b1;
         io_sram_lb              <= 1'b1;
      end else begin
         io_a_ack <= 1'b0;
         io_b_ack <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (io_a_req || io_b_req) begin
                  grant_b_reg    <= pick_b;
                  last_grant_reg <= pick_b;
                  cnt_reg        <= 4'd0;
                  io_sram_addr   <= sel_addr;
                  io_sram_cs     <= 1'b0;
                  if (sel_we) begin
                     state_reg               <= WR;
                     io_sram_we              <= 1'b0;
                     io_sram_ub              <= ~sel_be[1];
                     io_sram_lb              <= ~sel_be[0];
                     io_sram_dat_write       <= sel_wdata;
                     io_sram_dat_writeEnable <= 1'b1;
                  end else begin
                     state_reg  <= RD;
                     io_sram_oe <= 1'b0;
                     io_sram_ub <= 1'b0;
                     io_sram_lb <= 1'b0;
                  end
               end
            end
            RD: begin
               if (cnt_reg == RD_LAST) begin
                  state_reg  <= DONE;
                  io_rdata   <= io_sram_dat_read;
                  io_sram_cs <= 1'b1;
                  io_sram_oe <= 1'b1;
                  io_sram_ub <= 1'b1;
                  io_sram_lb <= 1'b1;
                  io_a_ack   <= ~grant_b_reg;
                  io_b_ack   <= grant_b_reg;
               end else begin
                  cnt_reg <= cnt_reg + 4'd1;
               end
            end
            WR: begin
               if (cnt_reg == WR_LAST) begin
                  state_reg  <= WHOLD;
                  io_sram_we <= 1'b1;
               end else begin
                  cnt_reg <= cnt_reg + 4'd1;
               end
            end
            WHOLD: begin
               // data stays driven one cycle past the WE rising edge
               state_reg               <= DONE;
               io_sram_cs              <= 1'b1;
               io_sram_ub              <= 1'b1;
               io_sram_lb              <= 1'b1;
               io_sram_dat_writeEnable <= 1'b0;
               io_a_ack                <= ~grant_b_reg;
               io_b_ack                <= grant_b_reg;
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/sram_arbiter.md
Name: sram_arbiter

Overview:
Two-port arbiter and sequencer for the board's external asynchronous 16-bit SRAM.
- Port A is the CPU data bus; port B is a secondary master (DMA/video).
- Grants one requester at a time, round-robin on contention.
- Generates active-low CS/OE/WE/UB/LB strobes with parameterised wait states and drives the tristate data-pin controls (read/write/writeEnable) feeding the SB_IO pad array.

Parameters:
ADDR_WIDTH, 18, SRAM word address width
DATA_WIDTH, 16, SRAM data width (two bytes, UB/LB)
READ_WAIT, 1, extra read-strobe cycles (0..15); read phase lasts READ_WAIT+1 cycles
WRITE_WAIT, 1, extra write-pulse cycles (0..15); WE-low phase lasts WRITE_WAIT+1 cycles

Ports:
io_mainClk  in  1  system clock
io_resetn  in  1  synchronous active-low reset
io_a_req  in  1  port A request; held with fields stable until io_a_ack
io_a_we  in  1  port A: 1 write, 0 read
io_a_addr  in  ADDR_WIDTH  port A word address
io_a_wdata  in  DATA_WIDTH  port A write data
io_a_be  in  2  port A byte enables {upper, lower}, writes only
io_a_ack  out  1  one-cycle completion pulse for port A
io_b_req, io_b_we, io_b_addr, io_b_wdata, io_b_be, io_b_ack  same as port A, for port B
io_rdata  out  DATA_WIDTH  read data; valid in the ack cycle, held until the next read completes
io_busy  out  1  high when not in IDLE
io_sram_addr  out  ADDR_WIDTH  SRAM address
io_sram_dat_read  in  DATA_WIDTH  pad input data
io_sram_dat_write  out  DATA_WIDTH  pad output data
io_sram_dat_writeEnable  out  1  pad output enable, active high
io_sram_cs, io_sram_oe, io_sram_we, io_sram_ub, io_sram_lb  out  1 each  active-low SRAM strobes

Behaviour:
- Clocking and reset: one clock, io_mainClk. Reset is synchronous and active-low on io_resetn.
- Reset values:
  - state=IDLE; cs/oe/we/ub/lb=1; dat_writeEnable=0.
  - addr, dat_write, io_rdata = 0; acks=0; busy=0.
  - last_grant=B, so A wins the first tie.
- Reset asserted mid-access: strobes are deasserted on the next edge and no ack is issued.
- All SRAM outputs are registered.
- Address, data, byte enables and direction are latched at grant. Requesters' later changes are ignored until the ack.
- FSM IDLE: strobes inactive.
  - Only one req high: grant that port.
  - Both high: grant the port that is not last_grant.
  - On grant: latch fields, update last_grant, load counter=0, go RD or WR.
- FSM RD: cs=0, oe=0, ub=lb=0 (full word; be ignored).
  - Runs for READ_WAIT+1 cycles.
  - On the last cycle, io_rdata <= io_sram_dat_read, then go DONE.
- FSM WR: cs=0, we=0, ub=~be[1], lb=~be[0], dat_writeEnable=1, dat_write=latched wdata.
  - Runs for WRITE_WAIT+1 cycles, then go WHOLD.
- FSM WHOLD: cs=0, we=1, dat_writeEnable=1, data unchanged for one cycle (hold time). Go DONE.
- FSM DONE: strobes inactive, dat_writeEnable=0, ack of the granted port=1 for exactly one cycle. Go IDLE.
- Latency from the IDLE cycle sampling req:
  - Read: ack at cycle READ_WAIT+2.
  - Write: ack at cycle WRITE_WAIT+3.
- Back-to-back: IDLE follows DONE, so a requester that keeps req high after ack is treated as a new request. No double-issue is possible because ack precedes the IDLE sample.
- Write with be=00: full write sequence, ub=lb=1 (no bytes written), ack still issued.
- Continuous contention: grants strictly alternate A,B,A,B; neither port starves.
- Never drive dat_writeEnable=1 while oe=0.
- Counter is 4 bits; it must not wrap within a phase.

Test Plan:
- Reset, then A reads 0x00010 with READ_WAIT=1 (SRAM model returns 0xBEEF) -> cs/oe low cycles 1-2, io_a_ack at cycle 3, io_rdata=0xBEEF, io_b_ack never.
- B writes 0x1234 to 0x3FFFF with be=01 (WRITE_WAIT=1) -> we low cycles 1-2, lb=0, ub=1, writeEnable high cycles 1-3, addr 0x3FFFF, io_b_ack at cycle 4; model upper byte unchanged.
- A and B both req reads from the same cycle, held after acks -> grant order A,B,A,B; each ack one cycle wide; io_rdata matches the requesting port's address.
- Write with be=00 -> ub=lb=1 throughout, memory unchanged, ack at cycle 4.
- io_resetn low during RD cycle 1 -> next edge cs=oe=1, no ack, state IDLE; a fresh A read after release completes normally.
- READ_WAIT=0, WRITE_WAIT=3 build -> read ack at cycle 2; write WE low exactly 4 cycles, ack at cycle 6.
